// File: rtl/spi_frame_rx_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg
// Shared types for the SPI frame receiver: byte and frame containers, the
// default frame length, and the receiver FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package pong_pkg;

  localparam int NUM_BYTES_DEFAULT = 10;

  typedef logic [7:0] byte_t;

  typedef byte_t frame_t [0:NUM_BYTES_DEFAULT-1];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    OVERRUN = 2'd2
  } spi_rx_state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// ----------------------------------------------------------------------------
// spi_frame_rx_if
// Bundles the SPI pins coming from the external master together with the
// frame outputs handed to the system side.
//   spi_sclk_i / spi_cs_n_i / spi_mosi_i : SPI mode-0 pins (master -> rx)
//   data_out[NUM_BYTES]                  : last good frame, byte 0 first
//   data_ready                           : one-cycle "data_out updated"
//   frame_err_o                          : one-cycle "frame discarded"
//   frame_cnt_o                          : good-frame counter (wraps)
// Modports: master drives the pins and observes outputs; slave is the rx.
// ----------------------------------------------------------------------------
interface spi_frame_rx_if #(
  parameter int NUM_BYTES = pong_pkg::NUM_BYTES_DEFAULT
);
  import pong_pkg::*;

  logic       spi_sclk_i;
  logic       spi_cs_n_i;
  logic       spi_mosi_i;
  byte_t      data_out [NUM_BYTES];
  logic       data_ready;
  logic       frame_err_o;
  logic [7:0] frame_cnt_o;

  modport master (
    output spi_sclk_i, spi_cs_n_i, spi_mosi_i,
    input  data_out, data_ready, frame_err_o, frame_cnt_o
  );

  modport slave (
    input  spi_sclk_i, spi_cs_n_i, spi_mosi_i,
    output data_out, data_ready, frame_err_o, frame_cnt_o
  );

endinterface

// File: rtl/spi_frame_rx_sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer bringing one asynchronous bit into the system
// clock domain. Reset loads RST_VAL so the line starts at its idle level.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronized output (STAGES cycles of latency)
// ----------------------------------------------------------------------------
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Plain shift chain: stage 0 samples the pin, the last stage is the only
  // one the rest of the design may look at.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// ----------------------------------------------------------------------------
// spi_frame_rx
// Oversampling SPI mode-0 slave receiver. SCLK, CS_n and MOSI are
// synchronized into sys_clk, edges are turned into strobes, and an FSM
// assembles MSB-first bytes into a staging buffer. A frame is published to
// data_out only if exactly NUM_BYTES whole bytes arrived inside one CS low
// period; any other frame is discarded with a frame_err_o pulse.
//   sys_clk_i : system clock (>= 4x SCLK)
//   sys_rst_i : asynchronous active-high reset
//   bus       : spi_frame_rx_if.slave (SPI pins in, frame outputs out)
// ----------------------------------------------------------------------------
module spi_frame_rx
  import pong_pkg::*;
#(
  parameter int NUM_BYTES   = NUM_BYTES_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_i,
  spi_frame_rx_if.slave  bus
);

  localparam int            CW   = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_BYTES);

  logic w_sclkSync, w_csSync, w_mosiSync;
  logic r_sclkPrev, r_csPrev;
  logic w_sclkRise, w_csFall, w_csRise;

  spi_rx_state_t r_state, w_nextState;
  logic          w_clearCnt, w_shiftEn, w_storeByte, w_commit, w_frameErr;

  logic [2:0]    r_bitCnt;
  logic [CW-1:0] r_byteCnt;
  logic [7:0]    r_shiftReg;
  logic [7:0]    w_newByte;
  byte_t         r_staging [NUM_BYTES];
  byte_t         r_dataOut [NUM_BYTES];
  logic          r_dataReady, r_frameErr;
  logic [7:0]    r_frameCnt;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_syncSclk (
    .i_clk(sys_clk_i), .i_rst(sys_rst_i), .i_d(bus.spi_sclk_i), .o_q(w_sclkSync)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_syncCs (
    .i_clk(sys_clk_i), .i_rst(sys_rst_i), .i_d(bus.spi_cs_n_i), .o_q(w_csSync)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_syncMosi (
    .i_clk(sys_clk_i), .i_rst(sys_rst_i), .i_d(bus.spi_mosi_i), .o_q(w_mosiSync)
  );

  // One extra flop per line remembers last cycle's synchronized level so
  // that edges become single-cycle strobes. Idle levels on reset keep a
  // spurious edge from appearing as reset is released with the bus idle.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_sclkPrev <= 1'b0;
      r_csPrev   <= 1'b1;
    end else begin
      r_sclkPrev <= w_sclkSync;
      r_csPrev   <= w_csSync;
    end
  end

  assign w_sclkRise = w_sclkSync & ~r_sclkPrev;
  assign w_csFall   = ~w_csSync & r_csPrev;
  assign w_csRise   = w_csSync & ~r_csPrev;
  assign w_newByte  = {r_shiftReg[6:0], w_mosiSync};

  // FSM state register.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath strobes. cs_rise is tested before sclk_rise so
  // an SCLK edge landing in the same cycle as the end of frame is dropped.
  always_comb begin
    w_nextState = r_state;
    w_clearCnt  = 1'b0;
    w_shiftEn   = 1'b0;
    w_storeByte = 1'b0;
    w_commit    = 1'b0;
    w_frameErr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_csFall) begin
          w_clearCnt  = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (w_csRise) begin
          if (r_byteCnt == FULL && r_bitCnt == 3'd0) begin
            w_commit = 1'b1;
          end else begin
            w_frameErr = 1'b1;
          end
          w_nextState = IDLE;
        end else if (w_sclkRise) begin
          w_shiftEn = 1'b1;
          if (r_bitCnt == 3'd7) begin
            if (r_byteCnt == FULL) begin
              w_frameErr  = 1'b1;
              w_nextState = OVERRUN;
            end else begin
              w_storeByte = 1'b1;
            end
          end
        end
      end
      OVERRUN: begin
        if (w_csRise) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: bit/byte counters, shifter, staging buffer and the published
  // frame. data_out is only copied from staging on a commit, so a bad
  // frame can scribble into staging without ever becoming visible.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_bitCnt    <= 3'd0;
      r_byteCnt   <= '0;
      r_shiftReg  <= 8'h00;
      r_dataReady <= 1'b0;
      r_frameErr  <= 1'b0;
      r_frameCnt  <= 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
        r_staging[i] <= 8'h00;
        r_dataOut[i] <= 8'h00;
      end
    end else begin
      r_dataReady <= w_commit;
      r_frameErr  <= w_frameErr;
      if (w_clearCnt) begin
        r_bitCnt  <= 3'd0;
        r_byteCnt <= '0;
      end else if (w_shiftEn) begin
        r_shiftReg <= w_newByte;
        r_bitCnt   <= r_bitCnt + 3'd1;
      end
      if (w_storeByte) begin
        r_staging[r_byteCnt] <= w_newByte;
        r_byteCnt            <= r_byteCnt + CW'(1);
      end
      if (w_commit) begin
        r_dataOut  <= r_staging;
        r_frameCnt <= r_frameCnt + 8'd1;
      end
    end
  end

  assign bus.data_out    = r_dataOut;
  assign bus.data_ready  = r_dataReady;
  assign bus.frame_err_o = r_frameErr;
  assign bus.frame_cnt_o = r_frameCnt;

endmodule

// File: tb/tb_spi_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_spi_frame_rx
// Directed bench for spi_frame_rx. dut0 uses the default 10-byte frame and
// is checked through a scoreboard: stimulus pushes the expected pulse (good
// frame or discard) and a monitor pops and compares on every output pulse.
// dut1 uses a 1-byte frame so the 8-bit frame counter can be wrapped with
// 256 short frames.
// ----------------------------------------------------------------------------
module tb_spi_frame_rx;
  import pong_pkg::*;

  typedef struct {
    bit         isErr;
    frame_t     data;
    logic [7:0] cnt;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  exp_t   expQ [$];
  exp_t   monExp;
  int     nChecks = 0;
  int     nPass   = 0;
  frame_t lastGood;
  logic [7:0] expCnt;
  int     readyCnt1 = 0;
  int     errCnt1   = 0;

  frame_t fA = '{8'h2C, 8'h01, 8'hF0, 8'h00, 8'h64, 8'h00, 8'hC8, 8'h01, 8'h03, 8'h07};
  frame_t fB = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
  frame_t fC = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E};
  frame_t fD = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'hFF, 8'h3C};
  frame_t fZero = '{default: 8'h00};

  always #5 clk = ~clk;

  spi_frame_rx_if #(.NUM_BYTES(10)) bus0 ();
  spi_frame_rx_if #(.NUM_BYTES(1))  bus1 ();

  spi_frame_rx #(.NUM_BYTES(10), .SYNC_STAGES(2)) dut0 (
    .sys_clk_i(clk), .sys_rst_i(rst), .bus(bus0)
  );
  spi_frame_rx #(.NUM_BYTES(1), .SYNC_STAGES(2)) dut1 (
    .sys_clk_i(clk), .sys_rst_i(rst), .bus(bus1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic pushExpect(input bit isErr);
    exp_t e;
    e.isErr = isErr;
    e.data  = lastGood;
    e.cnt   = expCnt;
    expQ.push_back(e);
  endtask

  // One SPI mode-0 bit: MOSI set while SCLK low, sampled on the rise.
  task automatic sendBit(input bit sel, input logic b);
    if (sel) bus1.spi_mosi_i = b; else bus0.spi_mosi_i = b;
    #20;
    if (sel) bus1.spi_sclk_i = 1'b1; else bus0.spi_sclk_i = 1'b1;
    #20;
    if (sel) bus1.spi_sclk_i = 1'b0; else bus0.spi_sclk_i = 1'b0;
  endtask

  task automatic sendByte(input bit sel, input byte_t b);
    for (int i = 7; i >= 0; i--) sendBit(sel, b[i]);
  endtask

  // Full dut0 frame: nBytes bytes (beyond 10 send 0xEE), extra loose bits,
  // then CS high. Optionally checks the CS-high to data_ready latency.
  task automatic applyStimulus(input frame_t f, input int nBytes, input int extraBits,
                               input bit checkLat);
    bus0.spi_cs_n_i = 1'b0;
    #30;
    for (int i = 0; i < nBytes; i++) begin
      if (i < 10) sendByte(1'b0, f[i]);
      else        sendByte(1'b0, 8'hEE);
    end
    for (int i = 0; i < extraBits; i++) sendBit(1'b0, 1'b1);
    #20;
    bus0.spi_cs_n_i = 1'b1;
    if (checkLat) begin
      @(posedge clk);
      @(posedge clk);
      #1 checkOutput("data_ready early", {31'd0, bus0.data_ready}, 32'd0);
      @(posedge clk);
      #1 checkOutput("data_ready latency", {31'd0, bus0.data_ready}, 32'd1);
      @(negedge clk);
    end
    #80;
  endtask

  // Scoreboard monitor for dut0: every output pulse must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (bus0.data_ready || bus0.frame_err_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse {ready,err}",
                    {30'd0, bus0.data_ready, bus0.frame_err_o}, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pulse data_ready", {31'd0, bus0.data_ready}, {31'd0, !monExp.isErr});
        checkOutput("pulse frame_err_o", {31'd0, bus0.frame_err_o}, {31'd0, monExp.isErr});
        checkOutput("pulse frame_cnt_o", {24'd0, bus0.frame_cnt_o}, {24'd0, monExp.cnt});
        for (int i = 0; i < 10; i++)
          checkOutput($sformatf("pulse data_out[%0d]", i),
                      {24'd0, bus0.data_out[i]}, {24'd0, monExp.data[i]});
      end
    end
  end

  // Pulse counters for the wrap test on dut1.
  always @(negedge clk) begin
    if (bus1.data_ready)  readyCnt1++;
    if (bus1.frame_err_o) errCnt1++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bus0.spi_sclk_i = 1'b0; bus0.spi_cs_n_i = 1'b1; bus0.spi_mosi_i = 1'b0;
    bus1.spi_sclk_i = 1'b0; bus1.spi_cs_n_i = 1'b1; bus1.spi_mosi_i = 1'b0;
    lastGood = fZero;
    expCnt   = 8'd0;
    #22;
    checkOutput("reset data_ready", {31'd0, bus0.data_ready}, 32'd0);
    checkOutput("reset frame_err_o", {31'd0, bus0.frame_err_o}, 32'd0);
    checkOutput("reset frame_cnt_o", {24'd0, bus0.frame_cnt_o}, 32'd0);
    checkOutput("reset data_out[0]", {24'd0, bus0.data_out[0]}, 32'd0);
    checkOutput("reset data_out[9]", {24'd0, bus0.data_out[9]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #40;

    $display("[TB] case 1: good 10-byte frame");
    lastGood = fA; expCnt = 8'd1; pushExpect(1'b0);
    applyStimulus(fA, 10, 0, 1'b1);
    checkOutput("case1 frame_cnt_o", {24'd0, bus0.frame_cnt_o}, 32'd1);

    $display("[TB] case 2: short 9-byte frame");
    pushExpect(1'b1);
    applyStimulus(fB, 9, 0, 1'b0);

    $display("[TB] case 3: 11-byte frame, then good frame");
    pushExpect(1'b1);
    applyStimulus(fC, 11, 0, 1'b0);
    lastGood = fB; expCnt = 8'd2; pushExpect(1'b0);
    applyStimulus(fB, 10, 0, 1'b0);

    $display("[TB] case 4: 10 bytes plus 3 bits");
    pushExpect(1'b1);
    applyStimulus(fC, 10, 3, 1'b0);

    $display("[TB] case 5: reset mid-frame, then good frame");
    bus0.spi_cs_n_i = 1'b0;
    #30;
    for (int i = 0; i < 4; i++) sendByte(1'b0, fC[i]);
    rst = 1'b1;
    #20 bus0.spi_cs_n_i = 1'b1;
    #40 rst = 1'b0;
    #40;
    lastGood = fZero; expCnt = 8'd0;
    checkOutput("case5 post-reset frame_cnt_o", {24'd0, bus0.frame_cnt_o}, 32'd0);
    checkOutput("case5 post-reset data_out[0]", {24'd0, bus0.data_out[0]}, 32'd0);
    lastGood = fD; expCnt = 8'd1; pushExpect(1'b0);
    applyStimulus(fD, 10, 0, 1'b0);
    checkOutput("case5 frame_cnt_o", {24'd0, bus0.frame_cnt_o}, 32'd1);

    $display("[TB] case 6a: SCLK toggling with CS high");
    for (int i = 0; i < 20; i++) sendBit(1'b0, i[0]);
    #80;
    checkOutput("case6 idle frame_cnt_o", {24'd0, bus0.frame_cnt_o}, 32'd1);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("case6 idle data_out[%0d]", i),
                  {24'd0, bus0.data_out[i]}, {24'd0, fD[i]});

    $display("[TB] case 6b: 256 good frames on 1-byte receiver");
    for (int k = 0; k < 256; k++) begin
      bus1.spi_cs_n_i = 1'b0;
      #30;
      sendByte(1'b1, k[7:0]);
      #20 bus1.spi_cs_n_i = 1'b1;
      #60;
      if (k == 254)
        checkOutput("wrap frame_cnt_o at 255", {24'd0, bus1.frame_cnt_o}, 32'd255);
    end
    checkOutput("wrap frame_cnt_o at 256", {24'd0, bus1.frame_cnt_o}, 32'd0);
    checkOutput("wrap data_ready pulses", readyCnt1, 32'd256);
    checkOutput("wrap frame_err_o pulses", errCnt1, 32'd0);
    checkOutput("wrap last data_out[0]", {24'd0, bus1.data_out[0]}, 32'hFF);

    #100;
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
